// File: rtl/uart_bridge_pkg.sv
// ============================================================================
// Module   : uart_bridge_pkg
// Purpose  : Shared FSM state type, default command bytes and byte helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_COLLECT = 2'd1,
    RD_SEND    = 2'd2,
    RD_WAIT    = 2'd3
  } state_t;

  localparam logic [7:0] CMD_RD_DEF     = 8'h52;
  localparam logic [7:0] CMD_WR_DEF     = 8'h57;
  localparam int         MAX_WORD_BYTES = 32;
  localparam int         MAX_W          = 8 * MAX_WORD_BYTES;

  // idx counts in wire order; nbytes is the real word size inside the
  // zero-extended MAX_W container.
  function automatic logic [7:0] byte_select(
    input logic [MAX_W-1:0] word,
    input int unsigned      idx,
    input logic             msb_first,
    input int unsigned      nbytes = MAX_WORD_BYTES
  );
    logic [MAX_W-1:0] tmp;
    int unsigned      lane;
    lane = msb_first ? (nbytes - 1 - idx) : idx;
    tmp  = word >> (8 * lane);
    return tmp[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_word_bridge_if.sv
// ============================================================================
// Module   : uart_word_bridge_if
// Purpose  : Byte-side UART handshake plus parallel word side of the bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_word_bridge_if #(
  parameter int W = 32
);
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         tx_done;
  logic [W-1:0] rd_word;
  logic [7:0]   tx_data;
  logic         tx_en;
  logic [W-1:0] wr_word;
  logic         wr_valid;
  logic         busy;
  logic         err;

  modport slave (
    input  rx_data, rx_done, tx_done, rd_word,
    output tx_data, tx_en, wr_word, wr_valid, busy, err
  );

  modport master (
    output rx_data, rx_done, tx_done, rd_word,
    input  tx_data, tx_en, wr_word, wr_valid, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/uart_bridge_timer.sv
// ============================================================================
// Module   : uart_bridge_timer
// Purpose  : Inter-byte timeout counter; holds at expiry until cleared.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_bridge_timer #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  output logic expired
);

  logic [31:0] cnt;

  assign expired = (cnt >= TIMEOUT_CYC);

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_word_bridge.sv
// ============================================================================
// Module   : uart_word_bridge
// Purpose  : Command-driven bridge between UART byte handshakes and a
//            WORD_BYTES-wide word (WORD_BYTES up to 32). Optional inter-byte
//            write timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_word_bridge
  import uart_bridge_pkg::*;
#(
  parameter int          WORD_BYTES  = 4,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter logic [7:0]  CMD_RD      = CMD_RD_DEF,
  parameter logic [7:0]  CMD_WR      = CMD_WR_DEF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
  input  logic                Clk,
  input  logic                Rst,
  uart_word_bridge_if.slave   bus
);

  localparam int            W    = 8 * WORD_BYTES;
  localparam int            CW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [W-1:0]     shreg, shreg_n;
  logic [W-1:0]     assembled;
  logic [MAX_W-1:0] ext;
  logic [7:0]       cur_byte;
  logic             tx_en_n, wr_valid_n, err_n;
  logic             timeout;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic timer_clear;
  // Counter only runs while collecting, restarting on every received byte.
  assign timer_clear = (state != WR_COLLECT) || bus.rx_done;

  uart_bridge_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (timer_clear),
    .expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    ext          = '0;
    ext[W-1:0]   = shreg;
    cur_byte     = byte_select(ext, 0, MSB_FIRST, WORD_BYTES);
    // New byte enters at the end opposite to the first-received byte.
    if (MSB_FIRST) begin
      assembled = (shreg << 8) | W'(bus.rx_data);
    end else begin
      assembled = (shreg >> 8) | (W'(bus.rx_data) << (W - 8));
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    shreg_n    = shreg;
    tx_en_n    = 1'b0;
    wr_valid_n = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_done) begin
          if (bus.rx_data == CMD_RD) begin
            shreg_n = bus.rd_word;
            count_n = '0;
            state_n = RD_SEND;
          end else if (bus.rx_data == CMD_WR) begin
            count_n = '0;
            state_n = WR_COLLECT;
          end
        end
      end
      RD_SEND: begin
        tx_en_n = 1'b1;
        err_n   = bus.rx_done;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        err_n = bus.rx_done;
        if (bus.tx_done) begin
          if (count == LAST) begin
            state_n = IDLE;
          end else begin
            count_n = count + 1'b1;
            shreg_n = MSB_FIRST ? (shreg << 8) : (shreg >> 8);
            state_n = RD_SEND;
          end
        end
      end
      WR_COLLECT: begin
        // A byte in the expiry cycle wins over the timeout.
        if (bus.rx_done) begin
          shreg_n = assembled;
          if (count == LAST) begin
            wr_valid_n = 1'b1;
            state_n    = IDLE;
          end else begin
            count_n = count + 1'b1;
          end
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count        <= '0;
      shreg        <= '0;
      bus.tx_data  <= '0;
      bus.tx_en    <= 1'b0;
      bus.wr_word  <= '0;
      bus.wr_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      count        <= count_n;
      shreg        <= shreg_n;
      bus.tx_en    <= tx_en_n;
      bus.wr_valid <= wr_valid_n;
      bus.busy     <= (state_n != IDLE);
      bus.err      <= err_n;
      if (tx_en_n) begin
        bus.tx_data <= cur_byte;
      end
      if (wr_valid_n) begin
        bus.wr_word <= assembled;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_word_bridge.sv
// ============================================================================
// Module   : tb_uart_word_bridge
// Purpose  : Directed self-checking bench for uart_word_bridge (three configs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_word_bridge;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  uart_word_bridge_if #(.W(32)) if_a ();
  uart_word_bridge_if #(.W(32)) if_b ();
  uart_word_bridge_if #(.W(16)) if_c ();

  uart_word_bridge #(.WORD_BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(32'd100))
    dut_a (.Clk(Clk), .Rst(Rst), .bus(if_a));
  uart_word_bridge #(.WORD_BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(32'd100))
    dut_b (.Clk(Clk), .Rst(Rst), .bus(if_b));
  uart_word_bridge #(.WORD_BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CYC(32'd100))
    dut_c (.Clk(Clk), .Rst(Rst), .bus(if_c));

  logic [7:0]  rxd  [3];
  logic        rxv  [3];
  logic        txdn [3];
  logic [31:0] rdw  [3];
  logic [7:0]  txd  [3];
  logic        txe  [3];
  logic        wrv  [3];
  logic        bsy  [3];
  logic        er   [3];
  logic [31:0] wrw  [3];

  assign if_a.rx_data = rxd[0];  assign if_a.rx_done = rxv[0];
  assign if_a.tx_done = txdn[0]; assign if_a.rd_word = rdw[0];
  assign if_b.rx_data = rxd[1];  assign if_b.rx_done = rxv[1];
  assign if_b.tx_done = txdn[1]; assign if_b.rd_word = rdw[1];
  assign if_c.rx_data = rxd[2];  assign if_c.rx_done = rxv[2];
  assign if_c.tx_done = txdn[2]; assign if_c.rd_word = rdw[2][15:0];

  assign txd[0] = if_a.tx_data; assign txe[0] = if_a.tx_en; assign wrw[0] = if_a.wr_word;
  assign wrv[0] = if_a.wr_valid; assign bsy[0] = if_a.busy; assign er[0] = if_a.err;
  assign txd[1] = if_b.tx_data; assign txe[1] = if_b.tx_en; assign wrw[1] = if_b.wr_word;
  assign wrv[1] = if_b.wr_valid; assign bsy[1] = if_b.busy; assign er[1] = if_b.err;
  assign txd[2] = if_c.tx_data; assign txe[2] = if_c.tx_en; assign wrw[2] = {16'h0, if_c.wr_word};
  assign wrv[2] = if_c.wr_valid; assign bsy[2] = if_c.busy; assign er[2] = if_c.err;

  int errc [3] = '{0, 0, 0};
  int wrvc [3] = '{0, 0, 0};
  int txec [3] = '{0, 0, 0};

  always @(negedge Clk) begin
    for (int d = 0; d < 3; d++) begin
      if (er[d])  errc[d] <= errc[d] + 1;
      if (wrv[d]) wrvc[d] <= wrvc[d] + 1;
      if (txe[d]) txec[d] <= txec[d] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] b);
    rxd[d] = b;
    rxv[d] = 1'b1;
    tick();
    rxv[d] = 1'b0;
  endtask

  task automatic pulse_txdone(input int d, input bit with_rx, input logic [7:0] b);
    txdn[d] = 1'b1;
    if (with_rx) begin
      rxd[d] = b;
      rxv[d] = 1'b1;
    end
    tick();
    txdn[d] = 1'b0;
    rxv[d]  = 1'b0;
  endtask

  task automatic wait_txe(input int d, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!txe[d] && n < 20);
  endtask

  // Read on dut_a; exp_seq lists the wire bytes first-to-last.
  task automatic do_read(input logic [31:0] word, input logic [31:0] exp_seq, input bit inject);
    int          n, e0, t0, v0;
    logic [31:0] sh;
    rdw[0] = word;
    e0 = errc[0]; t0 = txec[0]; v0 = wrvc[0];
    send(0, 8'h52);
    for (int i = 0; i < 4; i++) begin
      wait_txe(0, n);
      sh = exp_seq >> (24 - 8 * i);
      check($sformatf("rd_lat%0d", i), n, 2);
      check($sformatf("rd_byte%0d", i), {24'h0, txd[0]}, {24'h0, sh[7:0]});
      tick();
      if (inject && i == 1) send(0, 8'h57);
      tick();
      @(negedge Clk);
      check($sformatf("rd_hold%0d", i), {23'h0, txe[0], txd[0]}, {24'h0, sh[7:0]});
      check($sformatf("rd_busy%0d", i), {31'h0, bsy[0]}, 32'd1);
      pulse_txdone(0, inject && i == 3, 8'h52);
    end
    @(negedge Clk);
    check("rd_busy_fall", {31'h0, bsy[0]}, 32'd0);
    tick();
    check("rd_txe_cnt", txec[0] - t0, 4);
    check("rd_err_cnt", errc[0] - e0, inject ? 2 : 0);
    check("rd_no_wr", wrvc[0] - v0, 0);
  endtask

  initial begin
    int e0, v0, t0;
    Rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rxd[d] = 8'h00; rxv[d] = 1'b0; txdn[d] = 1'b0; rdw[d] = 32'h0;
    end
    repeat (3) tick();
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_tx_data",  {24'h0, txd[0]}, 32'h0);
    check("rst_tx_en",    {31'h0, txe[0]}, 32'h0);
    check("rst_wr_word",  wrw[0], 32'h0);
    check("rst_wr_valid", {31'h0, wrv[0]}, 32'h0);
    check("rst_busy",     {31'h0, bsy[0]}, 32'h0);
    check("rst_err",      {31'h0, er[0]}, 32'h0);

    // Non-command byte in IDLE is ignored.
    tick();
    e0 = errc[0];
    send(0, 8'h33);
    @(negedge Clk);
    check("idle_junk_busy", {31'h0, bsy[0]}, 32'h0);
    tick();
    check("idle_junk_err", errc[0] - e0, 0);

    do_read(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_read(32'hCAFEF00D, 32'hCAFEF00D, 1'b1);

    // LSB-first write.
    e0 = errc[1]; v0 = wrvc[1];
    send(1, 8'h57); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33);
    @(negedge Clk);
    check("wrb_early_valid", {31'h0, wrv[1]}, 32'h0);
    send(1, 8'h44);
    @(negedge Clk);
    check("wrb_valid", {31'h0, wrv[1]}, 32'h1);
    check("wrb_word", wrw[1], 32'h44332211);
    @(negedge Clk);
    check("wrb_valid_pulse", {31'h0, wrv[1]}, 32'h0);
    tick();
    check("wrb_err_cnt", errc[1] - e0, 0);
    check("wrb_valid_cnt", wrvc[1] - v0, 1);

    // MSB-first write, then reset in the middle of the next one.
    send(0, 8'h57); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
    @(negedge Clk);
    check("wra_word", wrw[0], 32'h11223344);
    tick();
    send(0, 8'h57); send(0, 8'hAA); send(0, 8'hBB);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_mid_tx_en", {31'h0, txe[0]}, 32'h0);
    check("rst_mid_busy",  {31'h0, bsy[0]}, 32'h0);
    check("rst_mid_word",  wrw[0], 32'h0);
    tick();
    send(0, 8'h57); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
    @(negedge Clk);
    check("rst_wr_valid2", {31'h0, wrv[0]}, 32'h1);
    check("rst_wr_word2",  wrw[0], 32'h01020304);

    // Two-byte word whose payload equals the command bytes.
    tick();
    t0 = txec[2];
    send(2, 8'h57); send(2, 8'h52); send(2, 8'h57);
    @(negedge Clk);
    check("wb2_valid", {31'h0, wrv[2]}, 32'h1);
    check("wb2_word",  wrw[2], 32'h00005257);
    @(negedge Clk);
    check("wb2_busy",  {31'h0, bsy[2]}, 32'h0);
    tick();
    check("wb2_no_tx", txec[2] - t0, 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
    e0 = errc[0]; v0 = wrvc[0];
    send(0, 8'h57); send(0, 8'h01);
    repeat (50) tick();
    @(negedge Clk);
    check("to_busy_mid", {31'h0, bsy[0]}, 32'h1);
    repeat (60) tick();
    @(negedge Clk);
    check("to_err_cnt",   errc[0] - e0, 1);
    check("to_no_valid",  wrvc[0] - v0, 0);
    check("to_word_kept", wrw[0], 32'h01020304);
    check("to_idle",      {31'h0, bsy[0]}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
